timer_cfg_arbiter: RTL and testbench
====================================

Name: timer_cfg_arbiter

Overview:
Shares the single timer peripheral's configuration bus among NUM_REQ bus requesters, such as the core, a DMA sequencer or debug, using round-robin arbitration and one transaction per grant. Tracks which requester owns the running timer, blocks configuration writes from non-owners, and routes the timer's timeout pulse to the owning requester only. Sits between the requesters and the timer's cfg_sel/cfg_wr/cfg_addr/cfg_wdata/cfg_rdata/irq port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, 2, width of requester index; must equal ceil(log2(NUM_REQ))

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, asynchronous, active-low
req_i  in  NUM_REQ  per-requester transaction request; held with payload until ack
wr_i  in  NUM_REQ  1 = write, 0 = read
addr_i  in  NUM_REQ*32  per-requester address, slice k = [32k+31:32k]
wdata_i  in  NUM_REQ*32  per-requester write data, same slicing
ack_o  out  NUM_REQ  one-cycle completion pulse to the granted requester
err_o  out  NUM_REQ  one-cycle pulse with ack when a write was blocked
rdata_o  out  32  registered read data, valid in the ack cycle
irq_o  out  NUM_REQ  timeout pulse routed to the owner
owner_o  out  IDX_W  current owner index
owner_vld_o  out  1  owner index valid
tmr_sel_o  out  1  timer cfg select
tmr_wr_o  out  1  timer cfg write
tmr_addr_o  out  32  timer cfg address
tmr_wdata_o  out  32  timer cfg write data
tmr_rdata_i  in  32  timer cfg read data (combinational from address)
tmr_irq_i  in  1  timer timeout pulse

Behaviour:
- Reset: all outputs 0. FSM = IDLE. Round-robin pointer last_gnt = NUM_REQ-1, so requester 0 wins first. owner = 0, owner_vld = 0.
- FSM has three states: IDLE, ISSUE, ACK.
- IDLE: if any req_i bit is set, grant the first requester found scanning from last_gnt+1 (mod NUM_REQ). Register gnt, latch its wr/addr/wdata, set last_gnt = gnt, go to ISSUE. Otherwise stay in IDLE.
- ISSUE (exactly one cycle):
  - Drive tmr_addr_o/tmr_wdata_o from the latched payload. tmr_sel_o = 1.
  - tmr_wr_o = latched wr AND NOT blocked.
  - Capture tmr_rdata_i into rdata_o. For blocked writes, rdata_o = 0.
  - Go to ACK.
- ACK (one cycle): ack_o[gnt] = 1; err_o[gnt] = blocked. Go to IDLE.
- A request is seen no earlier than cycle 0 in IDLE; tmr_sel_o is asserted in cycle 1 and ack_o in cycle 2. Minimum spacing between grants is 3 cycles.
- Requester rule: req_i must be low in the cycle after ack_o. A req_i still high in IDLE is treated as a new request.
- req_i changes outside IDLE are ignored; the payload is latched at grant.
- Outside ISSUE, tmr_sel_o = tmr_wr_o = 0, and tmr_addr_o/tmr_wdata_o hold their last values.
- Register decode uses addr[7:0]: CFG = 0x10 (bit0 enable, bit1 periodic), RELOAD = 0x14, COUNT = 0x18, STATUS = 0x1C.
- Blocking: a write to CFG or RELOAD is blocked when owner_vld = 1 and gnt != owner. Reads, and writes to any other address, are never blocked.
- Ownership update, at the end of ISSUE and only for non-blocked writes:
  - CFG with wdata[0] = 1: owner = gnt, owner_vld = 1.
  - CFG with wdata[0] = 0: owner_vld = 0.
- IRQ routing:
  - irq_o[owner] = tmr_irq_i registered (1-cycle latency), only if owner_vld = 1 in the cycle tmr_irq_i is high. All other irq_o bits stay 0.
  - If owner_vld = 0, tmr_irq_i is dropped.
  - If tmr_irq_i coincides with an ownership update, the pre-update owner/owner_vld are used.
  - Consecutive tmr_irq_i cycles produce consecutive irq_o pulses.
- Reset asserted mid-transaction: the transaction is abandoned, no ack is issued, and ownership is cleared.

Test Plan:
1. Requester 2 reads 0x14 after reset (timer RELOAD = 50) -> tmr_sel_o high in cycle 1 with tmr_wr_o = 0; ack_o = 4'b0100 in cycle 2; rdata_o = 50; err_o = 0.
2. req_i = 4'b1111 held (each requester re-requesting after ack) -> grant order 0,1,2,3,0; each ack 3 cycles apart.
3. Requester 1 writes CFG = 0x3 -> owner_o = 1, owner_vld_o = 1. Requester 3 then writes RELOAD = 100 -> tmr_wr_o = 0, ack_o[3] and err_o[3] both pulse, RELOAD unchanged. Requester 3 then reads COUNT -> no err, data returned.
4. With owner = 1, tmr_irq_i pulses -> irq_o = 4'b0010 one cycle later. Requester 1 writes CFG = 0 -> owner_vld_o = 0. Next tmr_irq_i pulse -> irq_o stays 0.
5. tmr_irq_i high in the same ISSUE cycle in which requester 0 writes CFG = 1 while owner_vld = 0 -> irq dropped; owner_o = 0 afterwards.
6. reset_n_i low during ISSUE of a write -> outputs 0, no ack. After release, req_i = 4'b1000 granted first, 3 cycles to ack.

Source files
------------

// File: rtl/timer_cfg_arbiter.sv
// timer_cfg_arbiter: round-robin arbiter that shares the timer configuration
// bus among NUM_REQ requesters, with one transaction per grant. It tracks
// which requester owns the running timer, blocks CFG/RELOAD writes from
// requesters that do not own it, and routes the timeout pulse to the owner.
module timer_cfg_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ-1:0]    wr_i,
    input  logic [NUM_REQ*32-1:0] addr_i,
    input  logic [NUM_REQ*32-1:0] wdata_i,
    output logic [NUM_REQ-1:0]    ack_o,
    output logic [NUM_REQ-1:0]    err_o,
    output logic [31:0]           rdata_o,
    output logic [NUM_REQ-1:0]    irq_o,
    output logic [IDX_W-1:0]      owner_o,
    output logic                  owner_vld_o,
    output logic                  tmr_sel_o,
    output logic                  tmr_wr_o,
    output logic [31:0]           tmr_addr_o,
    output logic [31:0]           tmr_wdata_o,
    input  logic [31:0]           tmr_rdata_i,
    input  logic                  tmr_irq_i
);

    localparam logic [7:0] REG_CFG    = 8'h10;
    localparam logic [7:0] REG_RELOAD = 8'h14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_ACK
    } state_e;

    state_e state_q, state_d;

    // The granted index doubles as the round-robin pointer; the next scan
    // starts one past it.
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic               latch;
    logic               wr_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               err_q;
    logic [31:0]        rdata_q;
    logic [IDX_W-1:0]   owner_q;
    logic               owner_vld_q;
    logic [NUM_REQ-1:0] irq_q, irq_d;

    logic               any_req;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;
    logic               blocked;

    logic [31:0] addr_arr  [NUM_REQ];
    logic [31:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = addr_i[32*g +: 32];
        assign wdata_arr[g] = wdata_i[32*g +: 32];
    end

    // Protected registers may only be written by the owner while ownership is held.
    assign blocked = wr_q
                   && ((addr_q[7:0] == REG_CFG) || (addr_q[7:0] == REG_RELOAD))
                   && owner_vld_q
                   && (gnt_q != owner_q);

    // Round-robin search: first requester found scanning from pointer+1.
    always_comb begin
        any_req = 1'b0;
        pick    = gnt_q;
        cand    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(gnt_q) + i) % NUM_REQ);
            if (!any_req && req_i[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    // Next-state and bus/handshake outputs of the transaction FSM.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        latch     = 1'b0;
        tmr_sel_o = 1'b0;
        tmr_wr_o  = 1'b0;
        ack_o     = '0;
        err_o     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_ISSUE;
                    gnt_d   = pick;
                    latch   = 1'b1;
                end
            end
            S_ISSUE: begin
                tmr_sel_o = 1'b1;
                tmr_wr_o  = wr_q & ~blocked;
                state_d   = S_ACK;
            end
            S_ACK: begin
                ack_o[gnt_q] = 1'b1;
                err_o[gnt_q] = err_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register, grant pointer and payload latched at grant.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            gnt_q   <= IDX_W'(NUM_REQ - 1);
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            if (latch) begin
                wr_q    <= wr_i[pick];
                addr_q  <= addr_arr[pick];
                wdata_q <= wdata_arr[pick];
            end
        end
    end

    // Completion status, read data capture and ownership update at end of ISSUE.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q       <= 1'b0;
            rdata_q     <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
        end else if (state_q == S_ISSUE) begin
            err_q   <= blocked;
            rdata_q <= blocked ? '0 : tmr_rdata_i;
            if (wr_q && !blocked && (addr_q[7:0] == REG_CFG)) begin
                if (wdata_q[0]) begin
                    owner_q     <= gnt_q;
                    owner_vld_q <= 1'b1;
                end else begin
                    owner_vld_q <= 1'b0;
                end
            end
        end
    end

    // Timeout routing uses the ownership in force during the pulse cycle.
    always_comb begin
        irq_d = '0;
        if (tmr_irq_i && owner_vld_q) begin
            irq_d[owner_q] = 1'b1;
        end
    end

    // Registered timeout pulse to the owner.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign rdata_o     = rdata_q;
    assign irq_o       = irq_q;
    assign owner_o     = owner_q;
    assign owner_vld_o = owner_vld_q;
    assign tmr_addr_o  = addr_q;
    assign tmr_wdata_o = wdata_q;

endmodule

// File: tb/tb_timer_cfg_arbiter.sv
// tb_timer_cfg_arbiter: table vectors, hand sequences for the multi-cycle
// corners, and random traffic checked against a transaction-level model.
module tb_timer_cfg_arbiter;

    localparam int NR = 4;

    logic             clk_i = 1'b0;
    logic             reset_n_i;
    logic [NR-1:0]    req_i;
    logic [NR-1:0]    wr_i;
    logic [NR*32-1:0] addr_i;
    logic [NR*32-1:0] wdata_i;
    logic [NR-1:0]    ack_o;
    logic [NR-1:0]    err_o;
    logic [31:0]      rdata_o;
    logic [NR-1:0]    irq_o;
    logic [1:0]       owner_o;
    logic             owner_vld_o;
    logic             tmr_sel_o;
    logic             tmr_wr_o;
    logic [31:0]      tmr_addr_o;
    logic [31:0]      tmr_wdata_o;
    logic [31:0]      tmr_rdata_i;
    logic             tmr_irq_i;

    timer_cfg_arbiter #(.NUM_REQ(NR), .IDX_W(2)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .req_i(req_i), .wr_i(wr_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o), .err_o(err_o),
        .rdata_o(rdata_o), .irq_o(irq_o), .owner_o(owner_o),
        .owner_vld_o(owner_vld_o), .tmr_sel_o(tmr_sel_o), .tmr_wr_o(tmr_wr_o),
        .tmr_addr_o(tmr_addr_o), .tmr_wdata_o(tmr_wdata_o),
        .tmr_rdata_i(tmr_rdata_i), .tmr_irq_i(tmr_irq_i)
    );

    always #5 clk_i = ~clk_i;

    // Timer peripheral stand-in: CFG, RELOAD, COUNT, STATUS decoded on addr[7:0].
    logic [31:0] dev_reg [4] = '{32'd0, 32'd50, 32'd777, 32'd0};

    always_comb begin
        case (tmr_addr_o[7:0])
            8'h10:   tmr_rdata_i = dev_reg[0];
            8'h14:   tmr_rdata_i = dev_reg[1];
            8'h18:   tmr_rdata_i = dev_reg[2];
            8'h1C:   tmr_rdata_i = dev_reg[3];
            default: tmr_rdata_i = 32'hDEAD_0000 | {24'h0, tmr_addr_o[7:0]};
        endcase
    end

    always @(posedge clk_i) begin
        if (tmr_sel_o && tmr_wr_o) begin
            case (tmr_addr_o[7:0])
                8'h10:   dev_reg[0] <= tmr_wdata_o;
                8'h14:   dev_reg[1] <= tmr_wdata_o;
                8'h18:   dev_reg[2] <= tmr_wdata_o;
                8'h1C:   dev_reg[3] <= tmr_wdata_o;
                default: ;
            endcase
        end
    end

    // Reference model state.
    logic [31:0] exp_reg [4] = '{32'd0, 32'd50, 32'd777, 32'd0};
    logic [1:0]  m_owner;
    logic        m_vld;
    int          m_last;
    logic        rnd_irq;

    logic        p_wr    [NR];
    logic [31:0] p_addr  [NR];
    logic [31:0] p_wdata [NR];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int reg_idx(input logic [31:0] a);
        case (a[7:0])
            8'h10:   return 0;
            8'h14:   return 1;
            8'h18:   return 2;
            8'h1C:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int ix;
        ix = reg_idx(a);
        if (ix < 0) return 32'hDEAD_0000 | {24'h0, a[7:0]};
        return exp_reg[ix];
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] m, input int last);
        for (int j = 1; j <= NR; j++) begin
            if (m[(last + j) % NR]) return (last + j) % NR;
        end
        return -1;
    endfunction

    task automatic set_payload(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d);
        p_wr[k] = wr;
        p_addr[k] = a;
        p_wdata[k] = d;
        wr_i[k] = wr;
        addr_i[32*k +: 32] = a;
        wdata_i[32*k +: 32] = d;
    endtask

    // Advance to the next falling edge and check the routed timeout pulse.
    task automatic tick(input logic nirq);
        logic [NR-1:0] e;
        e = (tmr_irq_i && m_vld) ? (4'b0001 << m_owner) : 4'b0000;
        @(negedge clk_i);
        chk("irq", irq_o, e);
        tmr_irq_i = rnd_irq ? ($urandom_range(0, 3) == 0) : nirq;
    endtask

    // One full transaction starting at the falling edge of an IDLE cycle.
    task automatic round(input logic irq_issue, output logic o_err, output logic [31:0] o_rd,
                         output logic [1:0] o_own, output logic o_vld);
        int w;
        int ix;
        logic blk;
        logic prot;
        logic [31:0] erd;
        logic [NR-1:0] oh;
        w = rr_pick(req_i, m_last);
        if (w < 0) w = 0;
        m_last = w;
        oh = 4'b0001 << w;
        prot = (p_addr[w][7:0] == 8'h10) || (p_addr[w][7:0] == 8'h14);
        blk = p_wr[w] && prot && m_vld && (m_owner != 2'(w));
        erd = blk ? 32'd0 : model_read(p_addr[w]);
        tick(irq_issue);
        chk("issue_sel", tmr_sel_o, 1);
        chk("issue_wr", tmr_wr_o, p_wr[w] & ~blk);
        chk("issue_addr", tmr_addr_o, p_addr[w]);
        if (p_wr[w] && !blk) chk("issue_wdata", tmr_wdata_o, p_wdata[w]);
        chk("issue_noack", ack_o, 0);
        tick(1'b0);
        if (p_wr[w] && !blk) begin
            ix = reg_idx(p_addr[w]);
            if (ix >= 0) exp_reg[ix] = p_wdata[w];
            if (p_addr[w][7:0] == 8'h10) begin
                if (p_wdata[w][0]) begin
                    m_owner = 2'(w);
                    m_vld = 1'b1;
                end else begin
                    m_vld = 1'b0;
                end
            end
        end
        chk("ack", ack_o, oh);
        chk("err", err_o, blk ? oh : 4'b0000);
        if (!p_wr[w] || blk) chk("rdata", rdata_o, erd);
        chk("owner", owner_o, m_owner);
        chk("owner_vld", owner_vld_o, m_vld);
        o_err = err_o[w];
        o_rd = rdata_o;
        o_own = owner_o;
        o_vld = owner_vld_o;
        req_i[w] = 1'b0;
        tick(1'b0);
        chk("idle_sel", tmr_sel_o, 0);
        chk("idle_ack", ack_o, 0);
    endtask

    task automatic txn(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic irq_issue);
        logic e;
        logic [31:0] r;
        logic [1:0] o;
        logic v;
        set_payload(k, wr, a, d);
        req_i[k] = 1'b1;
        round(irq_issue, e, r, o, v);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom();
        case ($urandom_range(0, 5))
            0, 1: a[7:0] = 8'h10;
            2:    a[7:0] = 8'h14;
            3:    a[7:0] = 8'h18;
            4:    a[7:0] = 8'h1C;
            default: ;
        endcase
        return a;
    endfunction

    typedef struct {
        int          k;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [1:0]  exp_owner;
        logic        exp_vld;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [15];
        logic        e_err;
        logic [31:0] e_rd;
        logic [1:0]  e_own;
        logic        e_vld;
        int          hold [NR];
        int          n_ack;
        int          cyc;
        int          last_cyc;
        int          prev;
        int          exp_last;
        int          exp_w;
        int          idx;
        int          k;
        logic [NR-1:0] msk;

        tbl[0]  = '{2, 1'b0, 32'h0000_0014, 32'h0,   1'b0, 1'b1, 32'd50,  2'd0, 1'b0};
        tbl[1]  = '{1, 1'b1, 32'h0000_0010, 32'h3,   1'b0, 1'b0, 32'd0,   2'd1, 1'b1};
        tbl[2]  = '{3, 1'b1, 32'h0000_0014, 32'd100, 1'b1, 1'b1, 32'd0,   2'd1, 1'b1};
        tbl[3]  = '{3, 1'b0, 32'h0000_0014, 32'h0,   1'b0, 1'b1, 32'd50,  2'd1, 1'b1};
        tbl[4]  = '{3, 1'b0, 32'h0000_0018, 32'h0,   1'b0, 1'b1, 32'd777, 2'd1, 1'b1};
        tbl[5]  = '{3, 1'b1, 32'h0000_0018, 32'd5,   1'b0, 1'b0, 32'd0,   2'd1, 1'b1};
        tbl[6]  = '{3, 1'b0, 32'h0000_0018, 32'h0,   1'b0, 1'b1, 32'd5,   2'd1, 1'b1};
        tbl[7]  = '{0, 1'b1, 32'h0000_0010, 32'h0,   1'b1, 1'b1, 32'd0,   2'd1, 1'b1};
        tbl[8]  = '{1, 1'b1, 32'h0000_0010, 32'h0,   1'b0, 1'b0, 32'd0,   2'd1, 1'b0};
        tbl[9]  = '{3, 1'b1, 32'h0000_0014, 32'd100, 1'b0, 1'b0, 32'd0,   2'd1, 1'b0};
        tbl[10] = '{0, 1'b0, 32'h0000_0014, 32'h0,   1'b0, 1'b1, 32'd100, 2'd1, 1'b0};
        tbl[11] = '{2, 1'b1, 32'h0000_0110, 32'h1,   1'b0, 1'b0, 32'd0,   2'd2, 1'b1};
        tbl[12] = '{2, 1'b0, 32'h0000_001C, 32'h0,   1'b0, 1'b1, 32'd0,   2'd2, 1'b1};
        tbl[13] = '{0, 1'b1, 32'hFFFF_FF14, 32'd7,   1'b1, 1'b1, 32'd0,   2'd2, 1'b1};
        tbl[14] = '{2, 1'b1, 32'h0000_0010, 32'h0,   1'b0, 1'b0, 32'd0,   2'd2, 1'b0};

        reset_n_i = 1'b0;
        req_i = '0;
        wr_i = '0;
        addr_i = '0;
        wdata_i = '0;
        tmr_irq_i = 1'b0;
        rnd_irq = 1'b0;
        m_owner = 2'd0;
        m_vld = 1'b0;
        m_last = NR - 1;
        for (int i = 0; i < NR; i++) set_payload(i, 1'b0, 32'h0, 32'h0);

        repeat (3) @(negedge clk_i);
        chk("rst_ack", ack_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_owner", owner_o, 0);
        chk("rst_vld", owner_vld_o, 0);
        chk("rst_sel", tmr_sel_o, 0);
        chk("rst_addr", tmr_addr_o, 0);
        reset_n_i = 1'b1;
        @(negedge clk_i);

        // Directed vector table: single-requester transactions.
        for (int i = 0; i < 15; i++) begin
            set_payload(tbl[i].k, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            req_i[tbl[i].k] = 1'b1;
            round(1'b0, e_err, e_rd, e_own, e_vld);
            chk($sformatf("tbl%0d_err", i), e_err, tbl[i].exp_err);
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), e_rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_owner", i), e_own, tbl[i].exp_owner);
            chk($sformatf("tbl%0d_vld", i), e_vld, tbl[i].exp_vld);
        end

        // Timeout routing to the owner, back-to-back pulses, drop when unowned.
        txn(1, 1'b1, 32'h10, 32'h3, 1'b0);
        tmr_irq_i = 1'b1;
        tick(1'b0);
        chk("irq_owner1", irq_o, 4'b0010);
        tmr_irq_i = 1'b1;
        tick(1'b1);
        chk("irq_consec_a", irq_o, 4'b0010);
        tick(1'b0);
        chk("irq_consec_b", irq_o, 4'b0010);
        tick(1'b0);
        chk("irq_consec_end", irq_o, 4'b0000);
        txn(1, 1'b1, 32'h10, 32'h0, 1'b0);
        tmr_irq_i = 1'b1;
        tick(1'b0);
        chk("irq_unowned", irq_o, 4'b0000);

        // Timeout coinciding with an ownership change uses the old ownership.
        txn(0, 1'b1, 32'h10, 32'h1, 1'b1);
        chk("claim_owner", owner_o, 0);
        chk("claim_vld", owner_vld_o, 1);
        txn(0, 1'b1, 32'h10, 32'h0, 1'b1);

        // Reset in the middle of a transaction.
        txn(1, 1'b1, 32'h10, 32'h1, 1'b0);
        set_payload(2, 1'b1, 32'h18, 32'd9);
        req_i[2] = 1'b1;
        @(negedge clk_i);
        chk("abort_sel_pre", tmr_sel_o, 1);
        reset_n_i = 1'b0;
        req_i = '0;
        #1;
        chk("abort_sel", tmr_sel_o, 0);
        chk("abort_wr", tmr_wr_o, 0);
        chk("abort_vld", owner_vld_o, 0);
        chk("abort_owner", owner_o, 0);
        chk("abort_rdata", rdata_o, 0);
        chk("abort_addr", tmr_addr_o, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("abort_no_ack", ack_o, 0);
        end
        reset_n_i = 1'b1;
        m_owner = 2'd0;
        m_vld = 1'b0;
        m_last = NR - 1;
        chk("abort_count_kept", dev_reg[2], exp_reg[2]);
        set_payload(3, 1'b0, 32'h14, 32'h0);
        req_i[3] = 1'b1;
        round(1'b0, e_err, e_rd, e_own, e_vld);
        chk("post_rst_rdata", e_rd, 32'd100);

        // All requesters contending: rotation order and 3-cycle ack spacing.
        for (int i = 0; i < NR; i++) begin
            set_payload(i, 1'b0, 32'h18, 32'h0);
            hold[i] = 0;
        end
        req_i = '1;
        n_ack = 0;
        cyc = 0;
        last_cyc = -1;
        prev = -1;
        exp_last = m_last;
        while (n_ack < 5 && cyc < 60) begin
            @(negedge clk_i);
            cyc++;
            for (int i = 0; i < NR; i++) begin
                if (hold[i] > 0) begin
                    hold[i]--;
                    if (hold[i] == 0) req_i[i] = 1'b1;
                end
            end
            if (ack_o != 0) begin
                idx = 0;
                for (int b = 0; b < NR; b++) if (ack_o[b]) idx = b;
                chk("rr_onehot", $countones(ack_o), 1);
                msk = '1;
                if (prev >= 0) msk[prev] = 1'b0;
                exp_w = rr_pick(msk, exp_last);
                chk($sformatf("rr_order%0d", n_ack), idx, exp_w);
                if (last_cyc < 0) chk("rr_first_latency", cyc, 2);
                else chk("rr_spacing", cyc - last_cyc, 3);
                last_cyc = cyc;
                exp_last = exp_w;
                prev = exp_w;
                req_i[idx] = 1'b0;
                hold[idx] = 2;
                n_ack++;
                if (n_ack == 5) req_i = '0;
            end
        end
        chk("rr_ack_count", n_ack, 5);
        m_last = exp_last;
        @(negedge clk_i);

        // Random contention, payloads and timeout pulses against the model.
        rnd_irq = 1'b1;
        for (int it = 0; it < 300; it++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_i[i] && i != m_last && $urandom_range(0, 1) == 1) begin
                    set_payload(i, 1'($urandom_range(0, 1)), rnd_addr(), $urandom());
                    req_i[i] = 1'b1;
                end
            end
            if (req_i == 0) begin
                k = (m_last + 1 + int'($urandom_range(0, NR - 2))) % NR;
                set_payload(k, 1'($urandom_range(0, 1)), rnd_addr(), $urandom());
                req_i[k] = 1'b1;
            end
            round(1'b0, e_err, e_rd, e_own, e_vld);
        end
        rnd_irq = 1'b0;
        tick(1'b0);
        tick(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
